// File: rtl/seq_detect_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : seq_detect_param
//  Purpose  : Serial bit-sequence detector with a runtime-loadable pattern,
//             overlap/non-overlap mode and a saturating match counter.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
   parameter int unsigned          PAT_LEN  = 4,
   parameter logic [PAT_LEN-1:0]   PAT_INIT = 4'b1011,
   parameter int unsigned          CNT_W    = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               din_valid,
   input  logic               datain,
   input  logic               overlap,
   input  logic               pat_load,
   input  logic [PAT_LEN-1:0] pat_in,
   input  logic               cnt_clr,
   output logic               yes,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               armed
);

   localparam int unsigned           FILL_W    = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0]     c_FULL    = FILL_W'(PAT_LEN);
   localparam logic [CNT_W-1:0]      c_CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      ST_FILL  = 1'b0,
      ST_ARMED = 1'b1
   } state_t;

   logic [PAT_LEN-1:0] pattern_q, pattern_d;
   logic [PAT_LEN-1:0] hist_q,    hist_d;
   logic [FILL_W-1:0]  fill_q,    fill_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic               yes_q,     yes_d;
   state_t             state_q,   state_d;

   logic [PAT_LEN-1:0] w_hist_shift;
   logic [FILL_W-1:0]  w_fill_inc;
   logic               w_hit;

   // A pattern load owns the edge: the bit arriving with it is discarded.
   always_comb begin
      w_hist_shift = {hist_q[PAT_LEN-2:0], datain};
      w_fill_inc   = (fill_q == c_FULL) ? c_FULL : fill_q + FILL_W'(1);
      w_hit        = din_valid && !pat_load &&
                     (w_fill_inc == c_FULL) && (w_hist_shift == pattern_q);
   end

   always_comb begin
      pattern_d = pattern_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      yes_d     = 1'b0;
      cnt_d     = cnt_q;

      if (pat_load) begin
         pattern_d = pat_in;
         hist_d    = '0;
         fill_d    = '0;
      end else if (din_valid) begin
         hist_d = w_hist_shift;
         yes_d  = w_hit;
         // Non-overlap mode demands PAT_LEN fresh bits before the next hit.
         fill_d = (w_hit && !overlap) ? '0 : w_fill_inc;
      end

      if (cnt_clr) begin
         cnt_d = '0;
      end else if (w_hit && (cnt_q != c_CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      state_d = (fill_d == c_FULL) ? ST_ARMED : ST_FILL;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pattern_q <= PAT_INIT;
         hist_q    <= '0;
         fill_q    <= '0;
         cnt_q     <= '0;
         yes_q     <= 1'b0;
         state_q   <= ST_FILL;
      end else begin
         pattern_q <= pattern_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         cnt_q     <= cnt_d;
         yes_q     <= yes_d;
         state_q   <= state_d;
      end
   end

   assign yes       = yes_q;
   assign match_cnt = cnt_q;
   assign armed     = (state_q == ST_ARMED);

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_seq_detect_param
//  Purpose  : Table-driven scoreboard bench for seq_detect_param (CNT_W=8 and 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

   logic       clk       = 1'b0;
   logic       reset     = 1'b0;
   logic       din_valid = 1'b0;
   logic       datain    = 1'b0;
   logic       overlap   = 1'b0;
   logic       pat_load  = 1'b0;
   logic [3:0] pat_in    = 4'b0000;
   logic       cnt_clr   = 1'b0;

   logic       yes8, armed8, yes2, armed2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;

   always #5 clk = ~clk;

   seq_detect_param #(.PAT_LEN(4), .PAT_INIT(4'b1011), .CNT_W(8)) dut8 (
      .clk(clk), .reset(reset), .din_valid(din_valid), .datain(datain),
      .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
      .yes(yes8), .match_cnt(cnt8), .armed(armed8)
   );

   seq_detect_param #(.PAT_LEN(4), .PAT_INIT(4'b1011), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .din_valid(din_valid), .datain(datain),
      .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
      .yes(yes2), .match_cnt(cnt2), .armed(armed2)
   );

   typedef struct {
      logic       vld;
      logic       din;
      logic       ld;
      logic [3:0] pin;
      logic       ovl;
      logic       clr;
      logic       e_yes;
      logic       e_armed;
   } vec_t;

   typedef struct {
      logic       yes;
      logic       armed;
      int         c8;
      int         c2;
      int         idx;
   } exp_t;

   vec_t  tbl[$];
   exp_t  sb[$];
   int    m8, m2;
   int    n_pass  = 0;
   int    n_total = 0;
   string tname   = "init";

   function automatic vec_t v(input logic vld, input logic din, input logic ld,
                              input logic [3:0] pin, input logic ovl, input logic clr,
                              input logic ey, input logic ea);
      vec_t t;
      t.vld = vld; t.din = din; t.ld = ld; t.pin = pin;
      t.ovl = ovl; t.clr = clr; t.e_yes = ey; t.e_armed = ea;
      return t;
   endfunction

   // d: '1'/'0' = valid bit, '-' = idle cycle; y/a: expected yes/armed after each edge
   task automatic add(input string d, input string y, input string a, input logic ovl);
      for (int i = 0; i < d.len(); i++) begin
         tbl.push_back(v(d[i] != "-", d[i] == "1", 1'b0, 4'b0000, ovl, 1'b0,
                         y[i] == "1", a[i] == "1"));
      end
   endtask

   task automatic check(input string what, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s %s: got %0d expected %0d", tname, what, act, exp);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " yes8"},   int'(yes8),   0);
      check({tag, " armed8"}, int'(armed8), 0);
      check({tag, " cnt8"},   int'(cnt8),   0);
      check({tag, " yes2"},   int'(yes2),   0);
      check({tag, " armed2"}, int'(armed2), 0);
      check({tag, " cnt2"},   int'(cnt2),   0);
   endtask

   task automatic idle_inputs();
      din_valid = 1'b0; datain = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
   endtask

   task automatic do_reset(input string name);
      tname = name;
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      #1;
      check_zero("reset");
      @(negedge clk);
      reset = 1'b1;
      m8 = 0; m2 = 0;
   endtask

   // Called right after a vector is checked: reset lands mid-cycle, away from any edge.
   task automatic async_reset();
      #2;
      reset = 1'b0;
      #1;
      check_zero("async_reset");
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      m8 = 0; m2 = 0;
   endtask

   task automatic apply(input vec_t t, input int idx);
      exp_t e;
      @(negedge clk);
      din_valid = t.vld; datain = t.din; pat_load = t.ld; pat_in = t.pin;
      overlap = t.ovl; cnt_clr = t.clr;
      if (t.clr) begin
         m8 = 0; m2 = 0;
      end else if (t.e_yes) begin
         if (m8 < 255) m8++;
         if (m2 < 3)   m2++;
      end
      e.yes = t.e_yes; e.armed = t.e_armed; e.c8 = m8; e.c2 = m2; e.idx = idx;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d yes8", e.idx),   int'(yes8),   int'(e.yes));
      check($sformatf("v%0d armed8", e.idx), int'(armed8), int'(e.armed));
      check($sformatf("v%0d cnt8", e.idx),   int'(cnt8),   e.c8);
      check($sformatf("v%0d yes2", e.idx),   int'(yes2),   int'(e.yes));
      check($sformatf("v%0d armed2", e.idx), int'(armed2), int'(e.armed));
      check($sformatf("v%0d cnt2", e.idx),   int'(cnt2),   e.c2);
   endtask

   task automatic run_tbl();
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
      tbl.delete();
   endtask

   initial begin
      m8 = 0; m2 = 0;

      do_reset("t1_basic");
      add("1011-", "00010", "00011", 1'b1);
      run_tbl();

      do_reset("t2_overlap");
      add("1011011", "0001001", "0001111", 1'b1);
      run_tbl();

      do_reset("t2_nonoverlap");
      add("10110110", "00010000", "00000001", 1'b0);
      run_tbl();

      do_reset("t3_load_drop");
      tbl.push_back(v(1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
      add("00000", "00011", "00011", 1'b1);
      run_tbl();

      do_reset("t4_gap");
      add("10-----11", "000000001", "000000001", 1'b1);
      run_tbl();

      do_reset("t5_saturate");
      tbl.push_back(v(1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
      add("000000000", "000111111", "000111111", 1'b1);
      tbl.push_back(v(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1));
      add("0", "1", "1", 1'b1);
      tbl.push_back(v(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0));
      add("1011", "0001", "0001", 1'b1);
      run_tbl();
      async_reset();

      do_reset("t6_midreset");
      add("1011101", "0001000", "0001111", 1'b1);
      run_tbl();
      async_reset();
      tname = "t6_after";
      add("1011", "0001", "0001", 1'b1);
      run_tbl();

      if (sb.size() != 0) check("scoreboard_leftover", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
